// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Contents: controller state enum, latched op-class enum, opcode/funct
// constants, datapath mux/ALU encodings, access-size codes, the wait-counter
// width, and a helper that classifies an opcode/funct pair.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_INIT, ST_FETCH, ST_DECODE, ST_ILLEGAL, ST_R_EXEC, ST_ADDI_EXEC,
        ST_ADDR, ST_MEM_RD, ST_MEM_WR, ST_WB, ST_BRANCH, ST_JUMP
    } state_e;

    typedef enum logic [3:0] {
        OPC_ILL, OPC_R, OPC_ADDI, OPC_LUI, OPC_LOAD, OPC_STORE,
        OPC_BEQ, OPC_BNE, OPC_J
    } op_class_e;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LW = 6'h23, OP_LH = 6'h21, OP_LB = 6'h20;
    localparam logic [5:0] OP_SW = 6'h2B, OP_SH = 6'h29, OP_SB = 6'h28;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
    localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_NONE = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3, ALU_OR = 3'd4, ALU_SLT = 3'd7;
    localparam logic [1:0] SRCB_REGB = 2'd0, SRCB_FOUR = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM_SH2 = 2'd3;
    localparam logic [1:0] PCIN_ALU = 2'd0, PCIN_ALUOUT = 2'd1, PCIN_JUMP = 2'd2;
    localparam logic [1:0] IORD_PC = 2'd0, IORD_ALUOUT = 2'd1;
    localparam logic [1:0] REGDST_RT = 2'd0, REGDST_RD = 2'd1, REGDST_SP = 2'd2;
    localparam logic [2:0] M2R_MDR = 3'd0, M2R_ALUOUT = 3'd1, M2R_LUI = 3'd2, M2R_SP_INIT = 3'd6;
    localparam logic [1:0] SZ_WORD = 2'd0, SZ_BYTE = 2'd1, SZ_HALF = 2'd2;

    localparam int CNT_W = $clog2(16);

    typedef struct packed {
        op_class_e   op_class;
        logic [2:0]  alu_op;
        logic [1:0]  size;
    } decode_t;

    // Unsupported opcodes and R-type functs both come back as OPC_ILL.
    function automatic decode_t decode_instr(input logic [5:0] opcode, input logic [5:0] funct);
        decode_t d;
        d.op_class = OPC_ILL;
        d.alu_op   = ALU_NONE;
        d.size     = SZ_WORD;
        case (opcode)
            OP_RTYPE: begin
                d.op_class = OPC_R;
                case (funct)
                    FN_ADD:  d.alu_op = ALU_ADD;
                    FN_SUB:  d.alu_op = ALU_SUB;
                    FN_AND:  d.alu_op = ALU_AND;
                    FN_OR:   d.alu_op = ALU_OR;
                    FN_SLT:  d.alu_op = ALU_SLT;
                    default: d.op_class = OPC_ILL;
                endcase
            end
            OP_ADDI: d.op_class = OPC_ADDI;
            OP_LUI:  d.op_class = OPC_LUI;
            OP_LW:   d.op_class = OPC_LOAD;
            OP_LH:   begin d.op_class = OPC_LOAD;  d.size = SZ_HALF; end
            OP_LB:   begin d.op_class = OPC_LOAD;  d.size = SZ_BYTE; end
            OP_SW:   d.op_class = OPC_STORE;
            OP_SH:   begin d.op_class = OPC_STORE; d.size = SZ_HALF; end
            OP_SB:   begin d.op_class = OPC_STORE; d.size = SZ_BYTE; end
            OP_BEQ:  d.op_class = OPC_BEQ;
            OP_BNE:  d.op_class = OPC_BNE;
            OP_J:    d.op_class = OPC_J;
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath bundle.
// master: the control unit (drives enables/selects, reads opcode, funct, alu_zero).
// slave : the datapath (drives instruction fields and the ALU zero flag).
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       pc_load, mem_write, ins_load, mdr_load;
    logic       regA_load, regB_load, aluout_load, reg_write;
    logic       mux_alusrcA;
    logic [1:0] mux_alusrcB, mux_pcin, mux_IorD, mux_regdst;
    logic [2:0] mux_mem2reg, alu_op;
    logic [1:0] adjsz_ctrl, memow_ctrl;
    logic       illegal_op;

    modport master (
        input  opcode, funct, alu_zero,
        output pc_load, mem_write, ins_load, mdr_load, regA_load, regB_load,
               aluout_load, reg_write, mux_alusrcA, mux_alusrcB, mux_pcin,
               mux_IorD, mux_regdst, mux_mem2reg, alu_op, adjsz_ctrl,
               memow_ctrl, illegal_op
    );

    modport slave (
        output opcode, funct, alu_zero,
        input  pc_load, mem_write, ins_load, mdr_load, regA_load, regB_load,
               aluout_load, reg_write, mux_alusrcA, mux_alusrcB, mux_pcin,
               mux_IorD, mux_regdst, mux_mem2reg, alu_op, adjsz_ctrl,
               memow_ctrl, illegal_op
    );
endinterface

// File: rtl/mc_wait_counter.sv
// Down-counter used for both memory wait states and store hold time.
// Ports: clk, rst (async, active-high), load_i/load_val_i (reload, wins over
// counting), en_i (count down, saturating at 0), done_o (count is 0).
module mc_wait_counter #(
    parameter int            W       = 4,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);
endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit (Moore FSM).
// Ports: clk, rst (async, active-high), bus (mc_control_fsm_if.master) carrying
// opcode/funct/alu_zero in and all datapath enables and mux selects out.
// Parameters: MEM_WAIT memory wait states (0..15), WR_HOLD store strobe length
// (1..15), SP_INIT_EN one-shot stack-pointer init after reset.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT   = 2,
    parameter int WR_HOLD    = 3,
    parameter bit SP_INIT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    mc_control_fsm_if.master bus
);
    localparam logic [CNT_W-1:0] MEM_WAIT_C   = CNT_W'(MEM_WAIT);
    localparam logic [CNT_W-1:0] WR_HOLD_LAST = CNT_W'(WR_HOLD - 1);
    localparam state_e           RST_STATE    = SP_INIT_EN ? ST_INIT : ST_FETCH;
    // Without the INIT cycle the first fetch begins straight out of reset,
    // so its wait count has to be preloaded.
    localparam logic [CNT_W-1:0] RST_CNT      = SP_INIT_EN ? '0 : MEM_WAIT_C;

    state_e           state_q, state_d;
    op_class_e        op_class_q, op_class_d;
    logic [2:0]       alu_fn_q, alu_fn_d;
    logic [1:0]       size_q, size_d;
    decode_t          dec;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_done;

    mc_wait_counter #(.W(CNT_W), .RST_VAL(RST_CNT)) u_wait (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (1'b1),
        .done_o     (cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RST_STATE;
            op_class_q <= OPC_ILL;
            alu_fn_q   <= ALU_NONE;
            size_q     <= SZ_WORD;
        end else begin
            state_q    <= state_d;
            op_class_q <= op_class_d;
            alu_fn_q   <= alu_fn_d;
            size_q     <= size_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        op_class_d       = op_class_q;
        alu_fn_d         = alu_fn_q;
        size_d           = size_q;
        dec              = decode_instr(bus.opcode, bus.funct);
        bus.pc_load      = 1'b0;
        bus.mem_write    = 1'b0;
        bus.ins_load     = 1'b0;
        bus.mdr_load     = 1'b0;
        bus.regA_load    = 1'b0;
        bus.regB_load    = 1'b0;
        bus.aluout_load  = 1'b0;
        bus.reg_write    = 1'b0;
        bus.mux_alusrcA  = 1'b0;
        bus.mux_alusrcB  = SRCB_REGB;
        bus.mux_pcin     = PCIN_ALU;
        bus.mux_IorD     = IORD_PC;
        bus.mux_regdst   = REGDST_RT;
        bus.mux_mem2reg  = M2R_MDR;
        bus.alu_op       = ALU_NONE;
        bus.adjsz_ctrl   = SZ_WORD;
        bus.memow_ctrl   = SZ_WORD;
        bus.illegal_op   = 1'b0;

        case (state_q)
            ST_INIT: begin
                state_d         = ST_FETCH;
                bus.reg_write   = 1'b1;
                bus.mux_regdst  = REGDST_SP;
                bus.mux_mem2reg = M2R_SP_INIT;
            end
            ST_FETCH: begin
                bus.mux_alusrcB = SRCB_FOUR;
                bus.alu_op      = ALU_ADD;
                if (cnt_done) begin
                    state_d      = ST_DECODE;
                    bus.ins_load = 1'b1;
                    bus.pc_load  = 1'b1;
                end
            end
            ST_DECODE: begin
                op_class_d      = dec.op_class;
                alu_fn_d        = dec.alu_op;
                size_d          = dec.size;
                bus.regA_load   = 1'b1;
                bus.regB_load   = 1'b1;
                bus.aluout_load = 1'b1;
                bus.mux_alusrcB = SRCB_IMM_SH2;
                bus.alu_op      = ALU_ADD;
                case (dec.op_class)
                    OPC_R:                state_d = ST_R_EXEC;
                    OPC_ADDI:             state_d = ST_ADDI_EXEC;
                    OPC_LUI:              state_d = ST_WB;
                    OPC_LOAD, OPC_STORE:  state_d = ST_ADDR;
                    OPC_BEQ, OPC_BNE:     state_d = ST_BRANCH;
                    OPC_J:                state_d = ST_JUMP;
                    default:              state_d = ST_ILLEGAL;
                endcase
            end
            ST_ILLEGAL: begin
                state_d        = ST_FETCH;
                bus.illegal_op = 1'b1;
            end
            ST_R_EXEC, ST_ADDI_EXEC: begin
                state_d         = ST_WB;
                bus.aluout_load = 1'b1;
                bus.mux_alusrcA = 1'b1;
                bus.mux_alusrcB = (state_q == ST_R_EXEC) ? SRCB_REGB : SRCB_IMM;
                bus.alu_op      = (state_q == ST_R_EXEC) ? alu_fn_q : ALU_ADD;
            end
            ST_ADDR: begin
                state_d         = (op_class_q == OPC_LOAD) ? ST_MEM_RD : ST_MEM_WR;
                bus.aluout_load = 1'b1;
                bus.mux_alusrcA = 1'b1;
                bus.mux_alusrcB = SRCB_IMM;
                bus.alu_op      = ALU_ADD;
            end
            ST_MEM_RD: begin
                bus.mux_IorD = IORD_ALUOUT;
                if (cnt_done) begin
                    state_d      = ST_WB;
                    bus.mdr_load = 1'b1;
                end
            end
            ST_MEM_WR: begin
                bus.mux_IorD   = IORD_ALUOUT;
                bus.memow_ctrl = size_q;
                bus.mem_write  = 1'b1;
                if (cnt_done) state_d = ST_FETCH;
            end
            ST_WB: begin
                state_d       = ST_FETCH;
                bus.reg_write = 1'b1;
                case (op_class_q)
                    OPC_R: begin
                        bus.mux_regdst  = REGDST_RD;
                        bus.mux_mem2reg = M2R_ALUOUT;
                    end
                    OPC_ADDI: bus.mux_mem2reg = M2R_ALUOUT;
                    OPC_LUI:  bus.mux_mem2reg = M2R_LUI;
                    default:  bus.adjsz_ctrl  = size_q;
                endcase
            end
            ST_BRANCH: begin
                state_d         = ST_FETCH;
                bus.mux_alusrcA = 1'b1;
                bus.alu_op      = ALU_SUB;
                bus.mux_pcin    = PCIN_ALUOUT;
                bus.pc_load     = ((op_class_q == OPC_BEQ) &&  bus.alu_zero) ||
                                  ((op_class_q == OPC_BNE) && !bus.alu_zero);
            end
            ST_JUMP: begin
                state_d      = ST_FETCH;
                bus.pc_load  = 1'b1;
                bus.mux_pcin = PCIN_JUMP;
            end
            default: state_d = ST_FETCH;
        endcase

        // Keep every strobe quiet while reset is held, even though the
        // state register already sits in INIT.
        if (rst) begin
            bus.pc_load     = 1'b0;
            bus.mem_write   = 1'b0;
            bus.ins_load    = 1'b0;
            bus.mdr_load    = 1'b0;
            bus.regA_load   = 1'b0;
            bus.regB_load   = 1'b0;
            bus.aluout_load = 1'b0;
            bus.reg_write   = 1'b0;
            bus.mux_alusrcA = 1'b0;
            bus.mux_alusrcB = SRCB_REGB;
            bus.mux_pcin    = PCIN_ALU;
            bus.mux_IorD    = IORD_PC;
            bus.mux_regdst  = REGDST_RT;
            bus.mux_mem2reg = M2R_MDR;
            bus.alu_op      = ALU_NONE;
            bus.adjsz_ctrl  = SZ_WORD;
            bus.memow_ctrl  = SZ_WORD;
            bus.illegal_op  = 1'b0;
        end

        // The wait counter is reloaded on every state change; only FETCH,
        // MEM_RD and MEM_WR ever look at it.
        cnt_load = (state_d != state_q);
        case (state_d)
            ST_FETCH, ST_MEM_RD: cnt_load_val = MEM_WAIT_C;
            ST_MEM_WR:           cnt_load_val = WR_HOLD_LAST;
            default:             cnt_load_val = '0;
        endcase
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench: four controller instances with different MEM_WAIT/WR_HOLD.
// Each stimulus process pushes the expected per-cycle control words for every
// instruction it issues; a monitor per instance pops and compares one word at
// every falling clock edge.
module tb_mc_control_fsm;

    localparam int NI = 4;
    localparam logic [15:0] MW_PACK = {4'd4, 4'd1, 4'd0, 4'd2};
    localparam logic [15:0] WH_PACK = {4'd5, 4'd3, 4'd2, 4'd3};
    localparam int N_DIR = 20;
    localparam int N_RND = 40;
    localparam int K_ILL = 0, K_R = 1, K_ADDI = 2, K_LUI = 3, K_LD = 4, K_ST = 5;
    localparam int K_BEQ = 6, K_BNE = 7, K_J = 8;

    typedef struct packed {
        logic       pc_load, mem_write, ins_load, mdr_load;
        logic       rega_load, regb_load, aluout_load, reg_write;
        logic       srca;
        logic [1:0] srcb, pcin, iord, regdst;
        logic [2:0] mem2reg, alu;
        logic [1:0] adjsz, memow;
        logic       illegal;
    } ctrl_t;

    logic  clk;
    ctrl_t exp_q [NI][$];
    bit    done  [NI];
    int    n_cmp;
    int    n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void push_zero(int idx);
        exp_q[idx].push_back('0);
    endfunction

    // Reference model: expected control words of one instruction, cycle by cycle.
    function automatic int push_instr(int idx, int mw, int wh, bit init,
                                      logic [5:0] op, logic [5:0] fn, bit z, int limit);
        ctrl_t      seq[$];
        ctrl_t      w;
        int         kind;
        logic [2:0] fa;
        logic [1:0] sz;
        int         n;
        kind = K_ILL; fa = 3'd0; sz = 2'd0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: fa = 3'd1;
                    6'h22: fa = 3'd2;
                    6'h24: fa = 3'd3;
                    6'h25: fa = 3'd4;
                    6'h2A: fa = 3'd7;
                    default: fa = 3'd0;
                endcase
                kind = (fa != 3'd0) ? K_R : K_ILL;
            end
            6'h08: kind = K_ADDI;
            6'h0F: kind = K_LUI;
            6'h23: kind = K_LD;
            6'h21: begin kind = K_LD; sz = 2'd2; end
            6'h20: begin kind = K_LD; sz = 2'd1; end
            6'h2B: kind = K_ST;
            6'h29: begin kind = K_ST; sz = 2'd2; end
            6'h28: begin kind = K_ST; sz = 2'd1; end
            6'h04: kind = K_BEQ;
            6'h05: kind = K_BNE;
            6'h02: kind = K_J;
            default: kind = K_ILL;
        endcase
        if (init) begin
            w = '0; w.reg_write = 1'b1; w.regdst = 2'd2; w.mem2reg = 3'd6;
            seq.push_back(w);
        end
        w = '0; w.srcb = 2'd1; w.alu = 3'd1;
        for (int i = 0; i < mw; i++) seq.push_back(w);
        w.ins_load = 1'b1; w.pc_load = 1'b1;
        seq.push_back(w);
        w = '0; w.rega_load = 1'b1; w.regb_load = 1'b1; w.aluout_load = 1'b1;
        w.srcb = 2'd3; w.alu = 3'd1;
        seq.push_back(w);
        w = '0;
        case (kind)
            K_ILL: begin w.illegal = 1'b1; seq.push_back(w); end
            K_R, K_ADDI: begin
                w.aluout_load = 1'b1; w.srca = 1'b1;
                w.srcb = (kind == K_R) ? 2'd0 : 2'd2;
                w.alu  = (kind == K_R) ? fa : 3'd1;
                seq.push_back(w);
                w = '0; w.reg_write = 1'b1; w.mem2reg = 3'd1;
                w.regdst = (kind == K_R) ? 2'd1 : 2'd0;
                seq.push_back(w);
            end
            K_LUI: begin w.reg_write = 1'b1; w.mem2reg = 3'd2; seq.push_back(w); end
            K_LD, K_ST: begin
                w.srca = 1'b1; w.srcb = 2'd2; w.alu = 3'd1; w.aluout_load = 1'b1;
                seq.push_back(w);
                w = '0; w.iord = 2'd1;
                if (kind == K_LD) begin
                    for (int i = 0; i < mw; i++) seq.push_back(w);
                    w.mdr_load = 1'b1;
                    seq.push_back(w);
                    w = '0; w.reg_write = 1'b1; w.mem2reg = 3'd0; w.adjsz = sz;
                    seq.push_back(w);
                end else begin
                    w.mem_write = 1'b1; w.memow = sz;
                    for (int i = 0; i < wh; i++) seq.push_back(w);
                end
            end
            K_BEQ, K_BNE: begin
                w.srca = 1'b1; w.srcb = 2'd0; w.alu = 3'd2; w.pcin = 2'd1;
                w.pc_load = (kind == K_BEQ) ? z : ~z;
                seq.push_back(w);
            end
            default: begin w.pc_load = 1'b1; w.pcin = 2'd2; seq.push_back(w); end
        endcase
        n = 0;
        foreach (seq[i]) begin
            if (n < limit) begin
                exp_q[idx].push_back(seq[i]);
                n++;
            end
        end
        return n;
    endfunction

    function automatic logic [12:0] dir_entry(int i);
        case (i)
            0:  return {6'h08, 6'h00, 1'b0};   // addi
            1:  return {6'h2B, 6'h00, 1'b0};   // sw
            2:  return {6'h28, 6'h00, 1'b0};   // sb
            3:  return {6'h04, 6'h00, 1'b1};   // beq taken
            4:  return {6'h04, 6'h00, 1'b0};   // beq not taken
            5:  return {6'h05, 6'h00, 1'b1};   // bne not taken
            6:  return {6'h05, 6'h00, 1'b0};   // bne taken
            7:  return {6'h3F, 6'h00, 1'b0};   // illegal opcode
            8:  return {6'h00, 6'h27, 1'b0};   // illegal funct
            9:  return {6'h23, 6'h00, 1'b0};   // lw
            10: return {6'h21, 6'h00, 1'b0};   // lh
            11: return {6'h20, 6'h00, 1'b0};   // lb
            12: return {6'h0F, 6'h00, 1'b0};   // lui
            13: return {6'h02, 6'h00, 1'b0};   // j
            14: return {6'h00, 6'h20, 1'b0};   // add
            15: return {6'h00, 6'h22, 1'b1};   // sub
            16: return {6'h00, 6'h24, 1'b0};   // and
            17: return {6'h00, 6'h25, 1'b0};   // or
            18: return {6'h00, 6'h2A, 1'b0};   // slt
            default: return {6'h29, 6'h00, 1'b0}; // sh
        endcase
    endfunction

    function automatic logic [5:0] fn_pick(int k);
        case (k)
            0: return 6'h20;
            1: return 6'h22;
            2: return 6'h24;
            3: return 6'h25;
            default: return 6'h2A;
        endcase
    endfunction

    function automatic logic [5:0] op_pick(int k);
        case (k)
            0: return 6'h08;
            1: return 6'h0F;
            2: return 6'h23;
            3: return 6'h21;
            4: return 6'h20;
            5: return 6'h2B;
            6: return 6'h29;
            7: return 6'h28;
            8: return 6'h04;
            9: return 6'h05;
            default: return 6'h02;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_inst
            localparam int MW = int'(MW_PACK[gi*4 +: 4]);
            localparam int WH = int'(WH_PACK[gi*4 +: 4]);
            logic rst;

            mc_control_fsm_if bus ();

            mc_control_fsm #(
                .MEM_WAIT   (MW),
                .WR_HOLD    (WH),
                .SP_INIT_EN (1'b1)
            ) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );

            initial begin : stim
                int         n;
                int         r;
                logic [12:0] ent;
                logic [5:0] op, fn;
                bit         z, init_pend;
                rst = 1'b1;
                bus.opcode = 6'h00; bus.funct = 6'h00; bus.alu_zero = 1'b0;
                @(posedge clk); #1;
                push_zero(gi); push_zero(gi);
                repeat (2) begin @(posedge clk); #1; end
                rst = 1'b0;
                init_pend = 1'b1;

                for (int i = 0; i < N_DIR; i++) begin
                    ent = dir_entry(i);
                    op = ent[12:7]; fn = ent[6:1]; z = ent[0];
                    bus.opcode = op; bus.funct = fn; bus.alu_zero = z;
                    n = push_instr(gi, MW, WH, init_pend, op, fn, z, 1000);
                    init_pend = 1'b0;
                    $display("inst%0d dir op=%h fn=%h zero=%0d cycles=%0d", gi, op, fn, z, n);
                    repeat (n) begin @(posedge clk); #1; end
                end

                // Store cut short by reset during its second mem_write cycle.
                bus.opcode = 6'h2B; bus.funct = 6'h00; bus.alu_zero = 1'b0;
                n = push_instr(gi, MW, WH, init_pend, 6'h2B, 6'h00, 1'b0,
                               (init_pend ? 1 : 0) + MW + 4);
                $display("inst%0d sw aborted by reset cycles=%0d", gi, n);
                repeat (n) begin @(posedge clk); #1; end
                rst = 1'b1;
                push_zero(gi);
                #1;
                n_cmp++;
                if (bus.mem_write !== 1'b0) begin
                    n_bad++;
                    $display("FAIL inst%0d rst_drops_mem_write actual=%0b required=0", gi, bus.mem_write);
                end
                @(posedge clk); #1;
                push_zero(gi);
                @(posedge clk); #1;
                rst = 1'b0;
                init_pend = 1'b1;

                for (int i = 0; i < N_RND; i++) begin
                    r  = int'($urandom_range(0, 15));
                    fn = 6'($urandom_range(0, 63));
                    z  = 1'($urandom_range(0, 1));
                    if (r <= 10) op = op_pick(r);
                    else if (r <= 12) begin op = 6'h00; fn = fn_pick(int'($urandom_range(0, 4))); end
                    else if (r == 13) op = 6'h00;
                    else op = 6'($urandom_range(0, 63));
                    bus.opcode = op; bus.funct = fn; bus.alu_zero = z;
                    n = push_instr(gi, MW, WH, init_pend, op, fn, z, 1000);
                    init_pend = 1'b0;
                    $display("inst%0d rnd op=%h fn=%h zero=%0d cycles=%0d", gi, op, fn, z, n);
                    repeat (n) begin @(posedge clk); #1; end
                end
                done[gi] = 1'b1;
            end

            initial begin : mon
                ctrl_t a, e;
                forever begin
                    @(negedge clk);
                    if (exp_q[gi].size() != 0) begin
                        e = exp_q[gi].pop_front();
                        a.pc_load     = bus.pc_load;
                        a.mem_write   = bus.mem_write;
                        a.ins_load    = bus.ins_load;
                        a.mdr_load    = bus.mdr_load;
                        a.rega_load   = bus.regA_load;
                        a.regb_load   = bus.regB_load;
                        a.aluout_load = bus.aluout_load;
                        a.reg_write   = bus.reg_write;
                        a.srca        = bus.mux_alusrcA;
                        a.srcb        = bus.mux_alusrcB;
                        a.pcin        = bus.mux_pcin;
                        a.iord        = bus.mux_IorD;
                        a.regdst      = bus.mux_regdst;
                        a.mem2reg     = bus.mux_mem2reg;
                        a.alu         = bus.alu_op;
                        a.adjsz       = bus.adjsz_ctrl;
                        a.memow       = bus.memow_ctrl;
                        a.illegal     = bus.illegal_op;
                        n_cmp++;
                        if (a !== e) begin
                            n_bad++;
                            $display("FAIL inst%0d ctrl_word t=%0t actual=%h required=%h", gi, $time, a, e);
                        end
                    end
                end
            end
        end
    endgenerate

    function automatic bit all_done();
        for (int i = 0; i < NI; i++) if (!done[i]) return 1'b0;
        return 1'b1;
    endfunction

    initial begin : finisher
        int cyc;
        cyc = 0;
        while (!all_done() && cyc < 60000) begin
            @(posedge clk);
            cyc++;
        end
        if (!all_done()) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout actual_cycles=%0d required=completion", cyc);
        end
        repeat (2) @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (exp_q[i].size() != 0) begin
                n_bad++;
                $display("FAIL inst%0d queue_drained actual=%0d required=0", i, exp_q[i].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
